// File: rtl/uart8_rx_controller_pkg.sv
// Shared UART definitions: oversample ratio, receiver bit-level states and
// the receive-controller FSM states.
// No ports (package).
package uart8_rx_controller_pkg;

    // Clock cycles per baud interval; the receiver and controller share this clock.
    localparam int unsigned Oversample = 16;

    // Bit-level states of the 8-bit receiver.
    typedef enum logic [1:0] {
        RxIdle,
        RxStart,
        RxData,
        RxStop
    } uart_rx_state_e;

    // Receive-controller states.
    typedef enum logic [1:0] {
        CtlOff,
        CtlArm,
        CtlRun,
        CtlHalt
    } uart_ctl_state_e;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous first-word-fall-through byte FIFO.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   wr_en, wr_data    write request and byte; a write while full is accepted
//                     only if a read happens in the same cycle
//   rd_en             pop the head (ignored when empty)
//   rd_data           current head, 0 when empty
//   full, empty       occupancy flags
module uart_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       rd_en,
    output logic [7:0] rd_data,
    output logic       full,
    output logic       empty
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] PtrInc = AW'(1);
    localparam logic [AW:0] CntInc = (AW + 1)'(1);
    localparam logic [AW:0] CntFull = (AW + 1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CntFull);
    assign pop     = rd_en & ~empty;
    assign push    = wr_en & (~full | pop);
    assign rd_data = empty ? 8'h00 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PtrInc;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrInc;
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CntInc;
            2'b01:   count_d = count_q - CntInc;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: emptiness is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: rtl/uart8_rx_controller.sv
// Receive controller for an 8-bit UART receiver: sequences the receiver
// enable, buffers received bytes toward the host, tracks overrun and error
// statistics, and flags end-of-message when the line goes idle.
// Ports:
//   clk, rst                 16x oversample clock, async active-high reset
//   enable                   software receive enable
//   clear_status             pulse clearing overrun and err_count
//   rx_busy/rx_done/rx_err   receiver status; rx_data valid while rx_done
//   rx_en                    registered enable to the receiver
//   m_valid/m_ready/m_data   host byte stream (m_data is 0 when empty)
//   overrun                  sticky dropped-byte flag
//   err_count                saturating receive error count
//   idle                     one-cycle end-of-message pulse
module uart8_rx_controller
    import uart8_rx_controller_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned IDLE_BAUDS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       clear_status,
    input  logic       rx_busy,
    input  logic       rx_done,
    input  logic       rx_err,
    input  logic [7:0] rx_data,
    output logic       rx_en,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       overrun,
    output logic [7:0] err_count,
    output logic       idle
);

    localparam int unsigned IdleLimit = IDLE_BAUDS * Oversample;
    localparam int unsigned IdleW = $clog2(IdleLimit + 1);
    localparam logic [IdleW-1:0] IdleMax = IdleW'(IdleLimit);
    localparam logic [IdleW-1:0] IdleInc = IdleW'(1);
    localparam logic [IdleW-1:0] IdleHit = IdleW'(IdleLimit - 1);

    uart_ctl_state_e state_q, state_d;
    logic             arm_cnt_q, arm_cnt_d;
    logic             rx_done_q, rx_err_q;
    logic             rx_en_q, rx_en_d;
    logic             overrun_q, overrun_d;
    logic [7:0]       err_count_q, err_count_d;
    logic [IdleW-1:0] idle_cnt_q, idle_cnt_d;
    logic             wrote_q, wrote_d;
    logic             idle_q, idle_d;

    logic done_edge, err_edge, active, running;
    logic wr_req, pop, accepted, drop;
    logic fifo_full, fifo_empty;

    assign done_edge = rx_done & ~rx_done_q;
    assign err_edge  = rx_err & ~rx_err_q;
    assign running   = (state_q == CtlRun);
    assign active    = running || (state_q == CtlHalt);
    assign wr_req    = done_edge & active;
    assign pop       = m_valid & m_ready;
    assign accepted  = wr_req & (~fifo_full | pop);
    assign drop      = wr_req & fifo_full & ~pop;

    uart_byte_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rst    (rst),
        .wr_en  (wr_req),
        .wr_data(rx_data),
        .rd_en  (m_ready),
        .rd_data(m_data),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    // Next-state logic. ARM lasts two cycles so the receiver can settle to idle.
    always_comb begin
        state_d   = state_q;
        arm_cnt_d = 1'b0;
        unique case (state_q)
            CtlOff: begin
                if (enable) state_d = CtlArm;
            end
            CtlArm: begin
                if (!enable) begin
                    state_d = CtlOff;
                end else if (arm_cnt_q) begin
                    state_d = CtlRun;
                end else begin
                    arm_cnt_d = 1'b1;
                end
            end
            CtlRun: begin
                if (!enable) state_d = rx_busy ? CtlHalt : CtlOff;
            end
            CtlHalt: begin
                if (enable) begin
                    state_d = CtlRun;
                end else if (!rx_busy || done_edge) begin
                    state_d = CtlOff;
                end
            end
            default: state_d = CtlOff;
        endcase
        rx_en_d = (state_d != CtlOff);
    end

    // Status and idle detection. Events take priority over clear_status.
    always_comb begin
        overrun_d = overrun_q;
        if (drop) begin
            overrun_d = 1'b1;
        end else if (clear_status) begin
            overrun_d = 1'b0;
        end

        err_count_d = err_count_q;
        if (err_edge && active) begin
            if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
        end else if (clear_status) begin
            err_count_d = 8'h00;
        end

        idle_cnt_d = idle_cnt_q;
        if (!running || rx_busy) begin
            idle_cnt_d = '0;
        end else if (idle_cnt_q != IdleMax) begin
            idle_cnt_d = idle_cnt_q + IdleInc;
        end

        // Registered pulse lands in the cycle the counter reaches the limit.
        idle_d  = running && !rx_busy && (idle_cnt_q == IdleHit) && wrote_q;
        wrote_d = accepted | (wrote_q & ~idle_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= CtlOff;
            arm_cnt_q   <= 1'b0;
            rx_done_q   <= 1'b0;
            rx_err_q    <= 1'b0;
            rx_en_q     <= 1'b0;
            overrun_q   <= 1'b0;
            err_count_q <= 8'h00;
            idle_cnt_q  <= '0;
            wrote_q     <= 1'b0;
            idle_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_cnt_q   <= arm_cnt_d;
            rx_done_q   <= rx_done;
            rx_err_q    <= rx_err;
            rx_en_q     <= rx_en_d;
            overrun_q   <= overrun_d;
            err_count_q <= err_count_d;
            idle_cnt_q  <= idle_cnt_d;
            wrote_q     <= wrote_d;
            idle_q      <= idle_d;
        end
    end

    assign rx_en     = rx_en_q;
    assign m_valid   = ~fifo_empty;
    assign overrun   = overrun_q;
    assign err_count = err_count_q;
    assign idle      = idle_q;

endmodule
